pipelined_mux_tree: RTL
=======================

# pipelined_mux_tree

- Parametrised, pipelined N:1 multiplexer tree. Successor to the fixed 512:1 single-bit mux.
- Adds the following over that block:
  - multi-bit lanes;
  - non-power-of-two input counts with out-of-range detection;
  - configurable register spacing inside the tree;
  - valid tagging and a global stall enable.
- Sits between the input hyper-pipeline and the output pipe in the mux top level, and replaces the external register chain plus combinational tree.

## Interface

Parameters:

- NUM_IN, 512: number of data inputs; 2 ≤ NUM_IN ≤ 2^SELWIDTH.
- SELWIDTH, 9: select width.
- DWIDTH, 1: bits per input lane.
- STAGE_LEVELS, 2: 2:1 tree levels between register stages; 1 ≤ STAGE_LEVELS ≤ SELWIDTH.

Ports:

- clk, input, 1: clock. All state changes on its rising edge.
- rst, input, 1: reset, asynchronous, active-low. Clears all pipeline state while low.
- en, input, 1: pipeline advance. 0 freezes every register in the block.
- din, input, NUM_IN*DWIDTH: lane i occupies bits [i*DWIDTH +: DWIDTH].
- sel, input, SELWIDTH: lane index.
- in_valid, input, 1: din/sel qualify a request.
- qout, output, DWIDTH: selected lane.
- qout_valid, output, 1: qout/qerr updated this cycle by a valid request.
- qerr, output, 1: last delivered request had sel ≥ NUM_IN.

## Operation

- **Stage 0 (input register):** when en=1, capture din, sel and in_valid. Also capture oor = (sel ≥ NUM_IN).
- **Tree structure:**
  - SELWIDTH levels of 2:1 muxes; level k uses sel bit k, so the LSB is consumed at the leaves.
  - Leaves with index ≥ NUM_IN are tied to zero.
  - The tree consists only of 2:1 mux levels.
- **Register stages:** a register stage follows every STAGE_LEVELS levels and also the final level. Number of tree stages S = ceil(SELWIDTH/STAGE_LEVELS).
- **Carried alongside the data:** each tree stage carries the remaining, not-yet-consumed sel bits, the valid bit and the oor bit. Sel bits already consumed are dropped.
- **Output stage:**
  - When the final stage holds valid=1 and en=1: qout ← tree result, or 0 if oor; qerr ← oor; qout_valid ← 1.
  - When the final stage holds valid=0 and en=1: qout and qerr hold; qout_valid ← 0.
- **Data registers and bubbles:** data registers load on every en=1 edge regardless of valid. Bubbles (in_valid=0) propagate and produce no output update.
- **Stall (en=0):**
  - All registers hold, including qout, qerr and qout_valid.
  - qout_valid therefore stays at its current value during a stall.
  - No request is lost or duplicated across a stall.
- **Width rules:** NUM_IN = 2^SELWIDTH makes oor constant 0. qerr then never asserts.

## Timing

- **Latency:** L = S + 1 enabled edges, with the capture edge counted as edge 1. Defaults: S = 5, L = 6.
- **Throughput:** one request per enabled cycle, with no bubbles inserted by the block.
- **Cycle mapping:** a request sampled at enabled edge n is visible on qout/qerr/qout_valid after enabled edge n+L−1. Edges with en=0 are not counted.
- **Reset (rst low, asynchronous):**
  - qout=0, qout_valid=0, qerr=0.
  - All stage valid bits = 0; all data and sel registers = 0.
  - Any requests in flight are discarded.
- **Reset release:** synchronous to clk. The first capture is at the first rising edge with rst high and en=1.
- **Reset asserted mid-stream:** outputs clear immediately, with no clock edge required. No request sampled before reset ever appears at the output.
- **en and in_valid together:** en=0 with in_valid=1 means the request is not sampled.

## Test plan

1. **Reset values.** Defaults; rst low with random din/sel and en=1 → qout=0, qout_valid=0, qerr=0 for all cycles while low. Also check 0 for L cycles after release when in_valid=0.
2. **Walking one, latency.** din = 1<<i for i = 0..511, sel=i, in_valid=1, en=1 every cycle → qout=1, qout_valid=1, qerr=0, each exactly 6 edges after capture.
   - Repeat with din = ~(1<<i) → qout=0.
3. **Stall.** Issue sel=37 with din[37]=1, then deassert en for 4 cycles mid-flight → output appears after 6 enabled edges (10 clock edges total). qout_valid is held during the stall, and there is no duplicate.
4. **Non-power-of-two range.** NUM_IN=300, SELWIDTH=9, DWIDTH=4, STAGE_LEVELS=3 (L=4), din all lanes = 4'hF:
   - sel=299 → qout=4'hF, qerr=0.
   - sel=300 → qout=0, qerr=1.
   - sel=511 → qout=0, qerr=1.
5. **Bubbles and hold.** Alternate in_valid 1/0 with sel=5 then sel=6 (lanes hold 4'hA and 4'h3) → qout_valid toggles 1/0, and qout holds 4'hA through the bubble cycle before 4'h3.
6. **Async reset mid-stream.** Stream 8 valid requests and pull rst low between clock edges at cycle 3 → outputs clear immediately. After release with in_valid=0, qout_valid stays 0 forever, so no stale request leaks.

Source files
------------

// File: rtl/pipelined_mux_tree.sv
// Parametrised N:1 multiplexer built from 2:1 levels with a register stage every
// STAGE_LEVELS levels, valid tagging, out-of-range detection and a global stall.
module pipelined_mux_tree #(
   parameter int NUM_IN       = 512,
   parameter int SELWIDTH     = 9,
   parameter int DWIDTH       = 1,
   parameter int STAGE_LEVELS = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     en,
   input  logic [NUM_IN*DWIDTH-1:0] din,
   input  logic [SELWIDTH-1:0]      sel,
   input  logic                     in_valid,
   output logic [DWIDTH-1:0]        qout,
   output logic                     qout_valid,
   output logic                     qerr
);

   localparam int NUM_STAGES = (SELWIDTH + STAGE_LEVELS - 1) / STAGE_LEVELS;
   localparam int LEAVES     = 2 ** SELWIDTH;
   localparam int LAST       = NUM_STAGES - 1;

   logic oor_in;

   generate
      if (NUM_IN >= LEAVES) begin : g_full
         assign oor_in = 1'b0;
      end else begin : g_part
         assign oor_in = (sel >= SELWIDTH'(NUM_IN));
      end
   endgenerate

   // Each g_stage holds a register boundary and the 2:1 levels that follow it.
   // The last stage's levels feed the output register directly.
   genvar b;
   generate
      for (b = 0; b < NUM_STAGES; b++) begin : g_stage
         localparam int REM       = SELWIDTH - b * STAGE_LEVELS;
         localparam int CONS      = (REM < STAGE_LEVELS) ? REM : STAGE_LEVELS;
         localparam int NODES     = 2 ** REM;
         localparam int OUT_NODES = 2 ** (REM - CONS);

         logic [NODES*DWIDTH-1:0]     nodes;
         logic [REM-1:0]              sel_q;
         logic                        valid_q;
         logic                        oor_q;
         logic [OUT_NODES*DWIDTH-1:0] mux_out;

         if (b == 0) begin : g_capture
            logic [NUM_IN*DWIDTH-1:0] din_q;

            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  din_q   <= '0;
                  sel_q   <= '0;
                  valid_q <= 1'b0;
                  oor_q   <= 1'b0;
               end else if (en) begin
                  din_q   <= din;
                  sel_q   <= sel;
                  valid_q <= in_valid;
                  oor_q   <= oor_in;
               end
            end

            // Leaves beyond NUM_IN are tied to zero.
            if (NUM_IN < LEAVES) begin : g_pad
               assign nodes = {{((LEAVES - NUM_IN) * DWIDTH){1'b0}}, din_q};
            end else begin : g_nopad
               assign nodes = din_q;
            end
         end else begin : g_pipe
            logic [NODES*DWIDTH-1:0] data_q;

            always_ff @(posedge clk or negedge rst) begin
               if (!rst) begin
                  data_q  <= '0;
                  sel_q   <= '0;
                  valid_q <= 1'b0;
                  oor_q   <= 1'b0;
               end else if (en) begin
                  data_q  <= g_stage[b-1].mux_out;
                  sel_q   <= g_stage[b-1].sel_q[REM+STAGE_LEVELS-1:STAGE_LEVELS];
                  valid_q <= g_stage[b-1].valid_q;
                  oor_q   <= g_stage[b-1].oor_q;
               end
            end

            assign nodes = data_q;
         end

         // Reduce in place: level l halves the node count using the lowest
         // not-yet-consumed select bit held by this stage.
         always_comb begin
            logic [DWIDTH-1:0] lvl [NODES];
            for (int i = 0; i < NODES; i++) begin
               lvl[i] = nodes[i*DWIDTH +: DWIDTH];
            end
            for (int l = 0; l < CONS; l++) begin
               for (int j = 0; j < (NODES >> (l + 1)); j++) begin
                  lvl[j] = sel_q[l] ? lvl[2*j+1] : lvl[2*j];
               end
            end
            for (int i = 0; i < OUT_NODES; i++) begin
               mux_out[i*DWIDTH +: DWIDTH] = lvl[i];
            end
         end
      end
   endgenerate

   // Bubbles leave qout/qerr untouched; only qout_valid follows the stage valid.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         qout       <= '0;
         qout_valid <= 1'b0;
         qerr       <= 1'b0;
      end else if (en) begin
         qout_valid <= g_stage[LAST].valid_q;
         if (g_stage[LAST].valid_q) begin
            qout <= g_stage[LAST].oor_q ? '0 : g_stage[LAST].mux_out;
            qerr <= g_stage[LAST].oor_q;
         end
      end
   end

endmodule
